response_signature_checker: RTL



---
 rtl/response_signature_checker.sv | 96 +++++++++
 1 files changed

// File: rtl/response_signature_checker.sv
// response_signature_checker: compacts a fixed-length window of valid
// circuit-under-test responses into a MISR signature. At the end of the
// window the signature is compared against a golden value.
module response_signature_checker #(
  parameter int              IN_W   = 1,
  parameter int              SIG_W  = 16,
  parameter logic [SIG_W-1:0] POLY  = 16'h1021,
  parameter logic [SIG_W-1:0] SEED  = 16'hFFFF,
  parameter int              CYCLES = 256,
  localparam int             CW     = $clog2(CYCLES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [IN_W-1:0]  resp_in,
  input  logic             resp_valid,
  input  logic [SIG_W-1:0] golden,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature,
  output logic [CW-1:0]    count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Count value held while absorbing the final response of the window.
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [1:0]       state;
  logic [SIG_W-1:0] resp_ext;
  logic [SIG_W-1:0] sig_next;

  // Next MISR value: shift with polynomial feedback, then fold in the response.
  always_comb begin
    resp_ext = '0;
    resp_ext[IN_W-1:0] = resp_in;
    sig_next = {signature[SIG_W-2:0], 1'b0}
             ^ (signature[SIG_W-1] ? POLY : '0)
             ^ resp_ext;
  end

  // Window control FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      signature <= '0;
      count     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_RUN;
            busy      <= 1'b1;
            signature <= SEED;
            count     <= '0;
          end
        end
        S_RUN: begin
          if (resp_valid) begin
            signature <= sig_next;
            count     <= count + 1'b1;
            if (count == LAST) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (sig_next == golden);
            end
          end
        end
        S_DONE: begin
          if (start) begin
            state     <= S_RUN;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            signature <= SEED;
            count     <= '0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          pass  <= 1'b0;
        end
      endcase
    end
  end

endmodule
